// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: machine word, fetch FSM states and BTB entry layout.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CTR_W  = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Tag is kept word-wide; the unused upper bits are always zero.
    typedef struct packed {
        logic             valid;
        word_t            tag;
        word_t            target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle: icache request, hazard/EX control inputs and IF/ID latch outputs.
interface pc_fetch_unit_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;
    logic  stall;
    logic  halt;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  resolve_valid;
    word_t resolve_pc;
    logic  resolve_taken;
    word_t resolve_target;
    logic  ifid_enable;
    logic  ifid_flush;
    word_t imemload_out;
    word_t pcp4_out;
    word_t inst_pc_out;
    word_t predicted_pc_out;

    // master: the fetch unit itself
    modport master (
        input  ihit, imemload, stall, halt,
        input  redirect_valid, redirect_pc,
        input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
        output imemREN, imemaddr,
        output ifid_enable, ifid_flush,
        output imemload_out, pcp4_out, inst_pc_out, predicted_pc_out
    );

    // slave: icache, hazard unit, EX stage and IF/ID latch seen as one environment
    modport slave (
        output ihit, imemload, stall, halt,
        output redirect_valid, redirect_pc,
        output resolve_valid, resolve_pc, resolve_taken, resolve_target,
        input  imemREN, imemaddr,
        input  ifid_enable, ifid_flush,
        input  imemload_out, pcp4_out, inst_pc_out, predicted_pc_out
    );

endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters (FETCH_BTB_EN builds only).
// Lookup is combinational on the current PC; training writes at the clock edge, so a
// same-cycle lookup of the trained index still sees the old entry.
`ifdef FETCH_BTB_EN
module fetch_btb
    import cpu_types_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic  CLK,
    input  logic  RST,
    input  word_t lookup_pc,
    input  word_t fallthru_pc,
    input  logic  resolve_valid,
    input  word_t resolve_pc,
    input  logic  resolve_taken,
    input  word_t resolve_target,
    output word_t predicted_pc
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_SH = IDX_W + 2;

    btb_entry_t       entries_q [ENTRIES];
    btb_entry_t       entries_d [ENTRIES];

    logic [IDX_W-1:0] lk_idx_c;
    logic [IDX_W-1:0] rs_idx_c;
    word_t            lk_tag_c;
    word_t            rs_tag_c;
    btb_entry_t       lk_ent_c;
    btb_entry_t       rs_old_c;
    btb_entry_t       rs_new_c;
    logic             lk_hit_c;

    assign lk_idx_c = lookup_pc[IDX_W+1:2];
    assign rs_idx_c = resolve_pc[IDX_W+1:2];
    assign lk_tag_c = lookup_pc >> TAG_SH;
    assign rs_tag_c = resolve_pc >> TAG_SH;

    // Prediction: taken only on a tag hit with a counter in the upper half.
    always_comb begin
        lk_ent_c     = entries_q[lk_idx_c];
        lk_hit_c     = lk_ent_c.valid && (lk_ent_c.tag == lk_tag_c);
        predicted_pc = fallthru_pc;
        if (lk_hit_c && lk_ent_c.ctr[1]) begin
            predicted_pc = lk_ent_c.target;
        end
    end

    // Training: hits move the counter, misses allocate a weakly-biased entry.
    always_comb begin
        entries_d = entries_q;
        rs_old_c  = entries_q[rs_idx_c];
        rs_new_c  = rs_old_c;
        if (rs_old_c.valid && (rs_old_c.tag == rs_tag_c)) begin
            if (resolve_taken && (rs_old_c.ctr != 2'd3)) begin
                rs_new_c.ctr = rs_old_c.ctr + 2'd1;
            end else if (!resolve_taken && (rs_old_c.ctr != 2'd0)) begin
                rs_new_c.ctr = rs_old_c.ctr - 2'd1;
            end
        end else begin
            rs_new_c.ctr = resolve_taken ? 2'd2 : 2'd1;
        end
        rs_new_c.valid  = 1'b1;
        rs_new_c.tag    = rs_tag_c;
        rs_new_c.target = resolve_target;
        if (resolve_valid) begin
            entries_d[rs_idx_c] = rs_new_c;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule
`endif

// File: rtl/pc_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, icache request and IF/ID latch control.
// Optional BTB prediction is built when FETCH_BTB_EN is defined; otherwise PC+4.
module pc_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT     = 32'h0000_0000,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input logic             CLK,
    input logic             RST,
    pc_fetch_unit_if.master fif
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    word_t        pc_q;
    word_t        pc_d;
    word_t        pend_pc_q;
    word_t        pend_pc_d;
    word_t        pcp4_c;
    word_t        pred_pc_c;
    logic         ifid_en_c;
    logic         ifid_flush_c;

    assign pcp4_c = pc_q + PC_STEP;

`ifdef FETCH_BTB_EN
    fetch_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .CLK            (CLK),
        .RST            (RST),
        .lookup_pc      (pc_q),
        .fallthru_pc    (pcp4_c),
        .resolve_valid  (fif.resolve_valid),
        .resolve_pc     (fif.resolve_pc),
        .resolve_taken  (fif.resolve_taken),
        .resolve_target (fif.resolve_target),
        .predicted_pc   (pred_pc_c)
    );
`else
    localparam int unsigned BTB_ENTRIES_UNUSED = BTB_ENTRIES;
    logic resolve_unused;

    assign pred_pc_c      = pcp4_c;
    assign resolve_unused = ^{fif.resolve_valid, fif.resolve_pc,
                              fif.resolve_taken, fif.resolve_target};
`endif

    // Next-state logic; priority halt > redirect > stall > ihit advance.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        case (state_q)
            RUN: begin
                if (fif.halt) begin
                    state_d = HALT;
                end else if (fif.redirect_valid) begin
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    if (fif.ihit) begin
                        pc_d = fif.redirect_pc;
                    end else begin
                        pend_pc_d = fif.redirect_pc;
                        state_d   = DRAIN;
                    end
                end else if (fif.ihit && !fif.stall) begin
                    ifid_en_c = 1'b1;
                    pc_d      = pred_pc_c;
                end
            end
            // Wait for the outstanding miss at pc_q; its data is discarded.
            DRAIN: begin
                if (fif.halt) begin
                    state_d = HALT;
                end else if (fif.redirect_valid) begin
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    if (fif.ihit) begin
                        pc_d    = fif.redirect_pc;
                        state_d = RUN;
                    end else begin
                        pend_pc_d = fif.redirect_pc;
                    end
                end else if (fif.ihit) begin
                    pc_d    = pend_pc_q;
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RUN;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // Request and latch strobes are forced low while reset is held.
    assign fif.imemREN          = !RST && (state_q != HALT);
    assign fif.imemaddr         = pc_q;
    assign fif.ifid_enable      = !RST && ifid_en_c;
    assign fif.ifid_flush       = !RST && ifid_flush_c;
    assign fif.imemload_out     = fif.imemload;
    assign fif.pcp4_out         = pcp4_c;
    assign fif.inst_pc_out      = pc_q;
    assign fif.predicted_pc_out = pred_pc_c;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand sequences and a
// randomized run against a behavioural fetch model (BTB model when FETCH_BTB_EN is set).
module tb_pc_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t       PC_INIT = 32'h0000_0000;
    localparam int unsigned BTB_N   = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pc_fetch_unit_if fif ();

    pc_fetch_unit #(
        .PC_INIT     (PC_INIT),
        .BTB_ENTRIES (BTB_N)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .fif (fif)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    word_t m_pc;
    bit    m_waiting;
    word_t m_target;
    bit    m_halted;
    word_t cur_load;

    // BTB model: remembers the last resolved branch PC per slot
    bit    b_v   [BTB_N];
    word_t b_pc  [BTB_N];
    word_t b_tgt [BTB_N];
    int    b_cnt [BTB_N];

    typedef struct {
        logic  ihit;
        logic  stall;
        logic  rv;
        word_t rpc;
        logic  e_en;
        logic  e_fl;
        word_t e_addr;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ihit, input logic stall, input logic halt,
                         input logic rv, input word_t rpc);
        fif.ihit           = ihit;
        fif.stall          = stall;
        fif.halt           = halt;
        fif.redirect_valid = rv;
        fif.redirect_pc    = rpc;
        cur_load           = $urandom();
        fif.imemload       = cur_load;
    endtask

    task automatic drive_res(input logic v, input word_t pc, input logic tk, input word_t tgt);
        fif.resolve_valid  = v;
        fif.resolve_pc     = pc;
        fif.resolve_taken  = tk;
        fif.resolve_target = tgt;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic word_t model_pred(input word_t pc);
        word_t p;
        p = pc + 32'd4;
`ifdef FETCH_BTB_EN
        begin
            int i;
            i = int'((pc >> 2) % BTB_N);
            if (b_v[i] && (b_pc[i] / (4 * BTB_N)) == (pc / (4 * BTB_N)) && b_cnt[i] >= 2)
                p = b_tgt[i];
        end
`endif
        return p;
    endfunction

    function automatic void model_train(input word_t pc, input bit tk, input word_t tgt);
        int i;
        i = int'((pc >> 2) % BTB_N);
        if (b_v[i] && (b_pc[i] / (4 * BTB_N)) == (pc / (4 * BTB_N)))
            b_cnt[i] = tk ? ((b_cnt[i] == 3) ? 3 : b_cnt[i] + 1)
                          : ((b_cnt[i] == 0) ? 0 : b_cnt[i] - 1);
        else
            b_cnt[i] = tk ? 2 : 1;
        b_v[i]   = 1'b1;
        b_pc[i]  = pc;
        b_tgt[i] = tgt;
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        drive_res(1'b0, '0, 1'b0, '0);
        #4;
        chk("rst_imemREN", word_t'(fif.imemREN), 32'd0);
        chk("rst_ifid_enable", word_t'(fif.ifid_enable), 32'd0);
        chk("rst_ifid_flush", word_t'(fif.ifid_flush), 32'd0);
        chk("rst_inst_pc", fif.inst_pc_out, PC_INIT);
        chk("rst_pcp4", fif.pcp4_out, PC_INIT + 32'd4);
        tick();
        RST       = 1'b0;
        m_pc      = PC_INIT;
        m_waiting = 1'b0;
        m_target  = '0;
        m_halted  = 1'b0;
        for (int i = 0; i < int'(BTB_N); i++) begin
            b_v[i]   = 1'b0;
            b_cnt[i] = 0;
        end
    endtask

    initial begin
        // reset->stall->redirect-with-miss sequence; pc values from the fetch rules
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h04};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h08};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h08};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h08};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0C};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h10};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h10};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h10};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h40};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h44};

        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive_res(1'b0, '0, 1'b0, '0);
        tick();
        do_reset();

        for (int v = 0; v < 11; v++) begin
            drive(tbl[v].ihit, tbl[v].stall, 1'b0, tbl[v].rv, tbl[v].rpc);
            #4;
            chk($sformatf("vec%0d_addr", v), fif.imemaddr, tbl[v].e_addr);
            chk($sformatf("vec%0d_en", v), word_t'(fif.ifid_enable), word_t'(tbl[v].e_en));
            chk($sformatf("vec%0d_flush", v), word_t'(fif.ifid_flush), word_t'(tbl[v].e_fl));
            chk($sformatf("vec%0d_ren", v), word_t'(fif.imemREN), 32'd1);
            chk($sformatf("vec%0d_pcp4", v), fif.pcp4_out, tbl[v].e_addr + 32'd4);
            chk($sformatf("vec%0d_load", v), fif.imemload_out, cur_load);
            tick();
        end

        // wrap at the top of the address space (pc is 0x48 here)
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        #4;
        chk("wrap_redirect_addr", fif.imemaddr, 32'h48);
        chk("wrap_redirect_flush", word_t'(fif.ifid_flush), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        #4;
        chk("wrap_addr", fif.imemaddr, 32'hFFFF_FFFC);
        chk("wrap_pcp4", fif.pcp4_out, 32'h0);
        chk("wrap_pred", fif.predicted_pc_out, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        #4;
        chk("wrap_next_addr", fif.imemaddr, 32'h0);
        tick();

        // halt beats a simultaneous redirect, then reset out of HALT (pc is 4 here)
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        #4;
        chk("halt_addr", fif.imemaddr, 32'h4);
        chk("halt_en", word_t'(fif.ifid_enable), 32'd0);
        chk("halt_flush", word_t'(fif.ifid_flush), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
            #4;
            chk($sformatf("halted%0d_ren", k), word_t'(fif.imemREN), 32'd0);
            chk($sformatf("halted%0d_addr", k), fif.imemaddr, 32'h4);
            chk($sformatf("halted%0d_en", k), word_t'(fif.ifid_enable), 32'd0);
            tick();
        end
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #4;
        chk("post_halt_rst_addr", fif.imemaddr, PC_INIT);
        chk("post_halt_rst_ren", word_t'(fif.imemREN), 32'd1);
        tick();

`ifdef FETCH_BTB_EN
        // BTB training: two taken resolves then two not-taken resolves of pc 0x20
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            drive_res(1'b1, 32'h20, 1'b1, 32'h80);
            tick();
        end
        drive_res(1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h20);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        #4;
        chk("btb_taken_pred", fif.predicted_pc_out, 32'h80);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            drive_res(1'b1, 32'h20, 1'b0, 32'h80);
            tick();
        end
        drive_res(1'b0, '0, 1'b0, '0);
        #4;
        chk("btb_nt_pred", fif.predicted_pc_out, 32'h24);
        tick();
`endif

        // randomized run against the behavioural model
        do_reset();
        begin
            int halted_cycles;
            halted_cycles = 0;
            for (int c = 0; c < 3000; c++) begin
                logic  r_ihit, r_stall, r_halt, r_rv, r_res, r_tk;
                logic  e_en, e_fl;
                word_t r_rpc, r_rspc, r_tgt, e_pred;
                r_halt  = ($urandom_range(0, 299) == 0);
                r_rv    = ($urandom_range(0, 7) == 0);
                r_ihit  = ($urandom_range(0, 3) != 0);
                r_stall = m_waiting ? 1'b0 : ($urandom_range(0, 3) == 0);
                r_rpc   = word_t'($urandom_range(0, 63)) << 2;
                r_res   = ($urandom_range(0, 2) == 0);
                r_tk    = 1'(($urandom() >> 3) & 1);
                r_rspc  = word_t'($urandom_range(0, 63)) << 2;
                r_tgt   = word_t'($urandom_range(0, 63)) << 2;
                drive(r_ihit, r_stall, r_halt, r_rv, r_rpc);
                drive_res(r_res, r_rspc, r_tk, r_tgt);

                e_pred = model_pred(m_pc);
                e_en   = 1'b0;
                e_fl   = 1'b0;
                if (!m_halted && !r_halt) begin
                    if (r_rv) begin
                        e_en = 1'b1;
                        e_fl = 1'b1;
                    end else if (!m_waiting && r_ihit && !r_stall) begin
                        e_en = 1'b1;
                    end
                end
                #4;
                chk("rnd_ren", word_t'(fif.imemREN), word_t'(!m_halted));
                chk("rnd_addr", fif.imemaddr, m_pc);
                chk("rnd_en", word_t'(fif.ifid_enable), word_t'(e_en));
                chk("rnd_flush", word_t'(fif.ifid_flush), word_t'(e_fl));
                chk("rnd_inst_pc", fif.inst_pc_out, m_pc);
                chk("rnd_pcp4", fif.pcp4_out, m_pc + 32'd4);
                chk("rnd_pred", fif.predicted_pc_out, e_pred);
                chk("rnd_load", fif.imemload_out, cur_load);

                if (!m_halted) begin
                    if (r_halt) begin
                        m_halted = 1'b1;
                    end else if (r_rv) begin
                        if (r_ihit) begin
                            m_pc      = r_rpc;
                            m_waiting = 1'b0;
                        end else begin
                            m_waiting = 1'b1;
                            m_target  = r_rpc;
                        end
                    end else if (m_waiting) begin
                        if (r_ihit) begin
                            m_pc      = m_target;
                            m_waiting = 1'b0;
                        end
                    end else if (r_ihit && !r_stall) begin
                        m_pc = e_pred;
                    end
                    if (r_res) model_train(r_rspc, r_tk, r_tgt);
                end
                tick();

                if (m_halted) begin
                    halted_cycles++;
                    if (halted_cycles > 4) begin
                        halted_cycles = 0;
                        do_reset();
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
